conv2_frame_ctrl: RTL and testbench

CONV2_FRAME_CTRL -- requirements
Module: conv2_frame_ctrl

---
 rtl/conv2_frame_ctrl_if.sv | 38 +++
 rtl/conv2_frame_ctrl.sv | 146 ++++++++++++++
 tb/tb_conv2_frame_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv2_frame_ctrl_if.sv
// Bus bundle between the conv2 frame controller and its environment
// (feature buffer, conv datapath and the frame-level sequencer).
//
// Handshake semantics: there is no ready/backpressure on the read side.
// mem_rd_en is a one-cycle read strobe and the buffer returns data one
// cycle later, which is when dp_valid_in is high. pause is the only way
// to throttle reads. conv_valid is a one-cycle beat from the datapath.
// It is always consumed and cannot be refused.
interface conv2_frame_ctrl_if #(
    parameter int ADDR_BITS = 8
);
    logic                 start;
    logic                 pause;
    logic                 conv_valid;
    logic                 mem_rd_en;
    logic [ADDR_BITS-1:0] mem_addr;
    logic                 dp_valid_in;
    logic [2:0]           out_row;
    logic [2:0]           out_col;
    logic [6:0]           out_count;
    logic                 busy;
    logic                 done;
    logic                 err;

    // Controller side: it drives the strobes and status flags.
    modport master (
        input  start, pause, conv_valid,
        output mem_rd_en, mem_addr, dp_valid_in,
        output out_row, out_col, out_count, busy, done, err
    );

    // Environment side: it drives requests and datapath beats.
    modport slave (
        output start, pause, conv_valid,
        input  mem_rd_en, mem_addr, dp_valid_in,
        input  out_row, out_col, out_count, busy, done, err
    );
endinterface

// File: rtl/conv2_frame_ctrl.sv
// Frame controller for a KxK convolution engine. It streams one raster frame
// out of the feature buffer, counts the datapath output beats, tags each beat
// with its output (row, col) and reports end of frame or a drain timeout.
module conv2_frame_ctrl #(
    parameter int WIDTH     = 12,
    parameter int HEIGHT    = 12,
    parameter int K         = 5,
    parameter int ADDR_BITS = 8,
    parameter int DRAIN_MAX = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    conv2_frame_ctrl_if.master        bus,
    output logic [1:0]                dbg_state
);
    localparam int OUT_W     = WIDTH - K + 1;
    localparam int OUT_H     = HEIGHT - K + 1;
    localparam int N_OUT     = OUT_W * OUT_H;
    localparam int N_PIX     = WIDTH * HEIGHT;
    localparam int DCNT_BITS = $clog2(DRAIN_MAX + 1);

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(N_PIX - 1);
    localparam logic [6:0]           FULL      = 7'(N_OUT);
    localparam logic [DCNT_BITS-1:0] DCNT_LAST = DCNT_BITS'(DRAIN_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [6:0]             count_q, count_d;
    logic [DCNT_BITS-1:0]   dcnt_q, dcnt_d;
    logic                   err_q, err_d;
    logic                   dpv_q, dpv_d;

    logic                   rd_en;
    logic                   last_read;
    logic                   counting;
    logic                   accept;
    logic                   overflow;
    logic                   reach_full;

    // Per-cycle decode: read strobe, final read and beat acceptance.
    always_comb begin
        rd_en      = (state_q == S_FEED) && !bus.pause;
        last_read  = rd_en && (addr_q == LAST_ADDR);
        counting   = (state_q == S_FEED) || (state_q == S_DRAIN);
        accept     = counting && bus.conv_valid && (count_q != FULL);
        overflow   = counting && bus.conv_valid && (count_q == FULL);
        // Full either already or with the beat that arrives this cycle.
        reach_full = (count_q == FULL) ||
                     (accept && (count_q == (FULL - 7'd1)));
    end

    // Next-state and next-value logic for every register in the block.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        dcnt_d  = dcnt_q;
        err_d   = err_q;
        dpv_d   = rd_en;

        // Beat counting is state-independent apart from the counting window.
        // A beat after the count is full saturates and is flagged.
        if (accept) begin
            count_d = count_q + 7'd1;
        end
        if (overflow) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_FEED;
                    addr_d  = '0;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            S_FEED: begin
                // The address holds on the last pixel instead of running off
                // the end of the frame.
                if (rd_en && !last_read) begin
                    addr_d = addr_q + ADDR_BITS'(1);
                end
                if (last_read) begin
                    state_d = S_DRAIN;
                    dcnt_d  = '0;
                end
            end
            S_DRAIN: begin
                dcnt_d = dcnt_q + DCNT_BITS'(1);
                if (reach_full) begin
                    state_d = S_DONE;
                end else if (dcnt_q == DCNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            dcnt_q  <= '0;
            err_q   <= 1'b0;
            dpv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            dcnt_q  <= dcnt_d;
            err_q   <= err_d;
            dpv_q   <= dpv_d;
        end
    end

    // Row/col tags come from the count before the current beat is added.
    assign bus.out_row     = 3'(32'(count_q) / OUT_W);
    assign bus.out_col     = 3'(32'(count_q) % OUT_W);
    assign bus.out_count   = count_q;
    assign bus.mem_rd_en   = rd_en;
    assign bus.mem_addr    = addr_q;
    assign bus.dp_valid_in = dpv_q;
    assign bus.busy        = (state_q == S_FEED) || (state_q == S_DRAIN);
    assign bus.done        = (state_q == S_DONE);
    assign bus.err         = err_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_conv2_frame_ctrl.sv
// Directed bench for conv2_frame_ctrl at default parameters (12x12, K=5,
// 64 outputs, drain timeout 256). Cycle n is the interval after rising edge n.
// Inputs change at edge+1 and outputs are sampled at edge+2.
module tb_conv2_frame_ctrl;
    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         total;
    int         bad;

    conv2_frame_ctrl_if #(.ADDR_BITS(8)) bus ();

    conv2_frame_ctrl #(
        .WIDTH(12), .HEIGHT(12), .K(5), .ADDR_BITS(8), .DRAIN_MAX(256)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .dbg_state(dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.start = 1'b0; bus.pause = 1'b0; bus.conv_valid = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        tick(); tick(); #1;
        total++; if (bus.mem_rd_en !== 1'b0) begin bad++; $display("FAIL rst_rd_en got=%b exp=0", bus.mem_rd_en); end
        total++; if (bus.mem_addr !== 8'd0) begin bad++; $display("FAIL rst_addr got=%0d exp=0", bus.mem_addr); end
        total++; if (bus.dp_valid_in !== 1'b0) begin bad++; $display("FAIL rst_dpv got=%b exp=0", bus.dp_valid_in); end
        total++; if (bus.out_row !== 3'd0) begin bad++; $display("FAIL rst_row got=%0d exp=0", bus.out_row); end
        total++; if (bus.out_col !== 3'd0) begin bad++; $display("FAIL rst_col got=%0d exp=0", bus.out_col); end
        total++; if (bus.out_count !== 7'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", bus.out_count); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", bus.done); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", bus.err); end
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
        bus.pause = 1'b1; #1;
        total++; if (bus.mem_rd_en !== 1'b0) begin bad++; $display("FAIL rst_rd_en_pause got=%b exp=0", bus.mem_rd_en); end
        bus.pause = 1'b0;
        rst = 1'b0;
        #1;
    endtask

    // Nominal frame: start in cycle 0, reads in cycles 1..144, 64 beats in DRAIN.
    task automatic test_nominal();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        #1;
        for (int c = 1; c <= 144; c++) begin
            total++; if (bus.mem_rd_en !== 1'b1) begin bad++; $display("FAIL nom_rd_en cyc=%0d got=%b exp=1", c, bus.mem_rd_en); end
            total++; if (bus.mem_addr !== 8'(c - 1)) begin bad++; $display("FAIL nom_addr cyc=%0d got=%0d exp=%0d", c, bus.mem_addr, c - 1); end
            total++; if (bus.dp_valid_in !== (c >= 2)) begin bad++; $display("FAIL nom_dpv cyc=%0d got=%b exp=%b", c, bus.dp_valid_in, (c >= 2)); end
            total++; if (dbg_state !== 2'd1) begin bad++; $display("FAIL nom_feed cyc=%0d got=%0d exp=1", c, dbg_state); end
            tick(); #1;
        end
        // cycle 145: first DRAIN cycle, last read data still valid
        total++; if (dbg_state !== 2'd2) begin bad++; $display("FAIL nom_drain got=%0d exp=2", dbg_state); end
        total++; if (bus.mem_rd_en !== 1'b0) begin bad++; $display("FAIL nom_rd_off got=%b exp=0", bus.mem_rd_en); end
        total++; if (bus.dp_valid_in !== 1'b1) begin bad++; $display("FAIL nom_dpv145 got=%b exp=1", bus.dp_valid_in); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL nom_busy145 got=%b exp=1", bus.busy); end
        // beats in cycles 146..209
        for (int i = 0; i < 64; i++) begin
            tick();
            bus.conv_valid = 1'b1;
            #1;
            if (i == 0) begin
                total++; if (bus.dp_valid_in !== 1'b0) begin bad++; $display("FAIL nom_dpv146 got=%b exp=0", bus.dp_valid_in); end
            end
            total++; if (bus.out_count !== 7'(i)) begin bad++; $display("FAIL nom_count beat=%0d got=%0d exp=%0d", i, bus.out_count, i); end
            total++; if (bus.out_row !== 3'(i / 8)) begin bad++; $display("FAIL nom_row beat=%0d got=%0d exp=%0d", i, bus.out_row, i / 8); end
            total++; if (bus.out_col !== 3'(i % 8)) begin bad++; $display("FAIL nom_col beat=%0d got=%0d exp=%0d", i, bus.out_col, i % 8); end
            total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL nom_early_done beat=%0d got=%b exp=0", i, bus.done); end
        end
        tick();
        bus.conv_valid = 1'b0;
        #1;
        // cycle 210: DONE
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL nom_done got=%b exp=1", bus.done); end
        total++; if (bus.out_count !== 7'd64) begin bad++; $display("FAIL nom_final_count got=%0d exp=64", bus.out_count); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL nom_err got=%b exp=0", bus.err); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL nom_busy_done got=%b exp=0", bus.busy); end
        tick(); #1;
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL nom_done_pulse got=%b exp=0", bus.done); end
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL nom_idle got=%0d exp=0", dbg_state); end
        tick(); #1;
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL nom_done_pulse2 got=%b exp=0", bus.done); end
    endtask

    // conv_valid in IDLE must not touch the count left by the previous frame.
    task automatic test_ignored_idle();
        for (int j = 0; j < 3; j++) begin
            tick();
            bus.conv_valid = 1'b1;
            #1;
            total++; if (bus.out_count !== 7'd64) begin bad++; $display("FAIL idle_beat_count j=%0d got=%0d exp=64", j, bus.out_count); end
            total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL idle_beat_state j=%0d got=%0d exp=0", j, dbg_state); end
        end
        tick();
        bus.conv_valid = 1'b0;
        #1;
        total++; if (bus.out_count !== 7'd64) begin bad++; $display("FAIL idle_beat_count_end got=%0d exp=64", bus.out_count); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL idle_beat_err got=%b exp=0", bus.err); end
    endtask

    // Start during FEED is ignored; 64 beats land in FEED, then a 65th overflows.
    task automatic test_feed_overflow();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        #1;
        for (int c = 2; c <= 147; c++) begin
            tick();
            bus.start      = (c >= 10 && c <= 12);
            bus.conv_valid = (c >= 20 && c <= 84);
            #1;
            if (c <= 144) begin
                total++; if (bus.mem_addr !== 8'(c - 1)) begin bad++; $display("FAIL ovf_addr cyc=%0d got=%0d exp=%0d", c, bus.mem_addr, c - 1); end
                total++; if (bus.mem_rd_en !== 1'b1) begin bad++; $display("FAIL ovf_rd_en cyc=%0d got=%b exp=1", c, bus.mem_rd_en); end
            end
            if (c == 19) begin
                total++; if (bus.out_count !== 7'd0) begin bad++; $display("FAIL ovf_count0 got=%0d exp=0", bus.out_count); end
            end
            if (c >= 20 && c <= 84) begin
                total++; if (bus.out_count !== 7'((c <= 83) ? (c - 20) : 64)) begin bad++; $display("FAIL ovf_count cyc=%0d got=%0d exp=%0d", c, bus.out_count, (c <= 83) ? (c - 20) : 64); end
                total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL ovf_err_early cyc=%0d got=%b exp=0", c, bus.err); end
            end
            if (c == 85) begin
                total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL ovf_err got=%b exp=1", bus.err); end
                total++; if (bus.out_count !== 7'd64) begin bad++; $display("FAIL ovf_sat got=%0d exp=64", bus.out_count); end
            end
            if (c == 145) begin
                total++; if (dbg_state !== 2'd2) begin bad++; $display("FAIL ovf_drain got=%0d exp=2", dbg_state); end
                total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL ovf_done145 got=%b exp=0", bus.done); end
            end
            if (c == 146) begin
                total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL ovf_done got=%b exp=1", bus.done); end
                total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL ovf_err_sticky got=%b exp=1", bus.err); end
                total++; if (bus.out_count !== 7'd64) begin bad++; $display("FAIL ovf_final_count got=%0d exp=64", bus.out_count); end
            end
            if (c == 147) begin
                total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL ovf_idle got=%0d exp=0", dbg_state); end
            end
        end
        bus.start = 1'b0;
        bus.conv_valid = 1'b0;
    endtask

    // Pause for 5 cycles when addr 50 is presented (cycles 51..55).
    task automatic test_pause();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        #1;
        for (int c = 2; c <= 151; c++) begin
            tick();
            bus.pause = (c >= 51 && c <= 55);
            #1;
            if (c <= 149) begin
                total++; if (bus.mem_addr !== 8'((c <= 51) ? (c - 1) : ((c <= 56) ? 50 : (c - 6)))) begin bad++; $display("FAIL pause_addr cyc=%0d got=%0d", c, bus.mem_addr); end
                total++; if (dbg_state !== 2'd1) begin bad++; $display("FAIL pause_feed cyc=%0d got=%0d exp=1", c, dbg_state); end
            end else begin
                total++; if (dbg_state !== 2'd2) begin bad++; $display("FAIL pause_drain cyc=%0d got=%0d exp=2", c, dbg_state); end
            end
            total++; if (bus.mem_rd_en !== ((c <= 149) && !(c >= 51 && c <= 55))) begin bad++; $display("FAIL pause_rd_en cyc=%0d got=%b", c, bus.mem_rd_en); end
            total++; if (bus.dp_valid_in !== ((c <= 150) && !(c >= 52 && c <= 56))) begin bad++; $display("FAIL pause_dpv cyc=%0d got=%b", c, bus.dp_valid_in); end
        end
        bus.pause = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            bus.conv_valid = 1'b1;
        end
        tick();
        bus.conv_valid = 1'b0;
        #1;
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL pause_done got=%b exp=1", bus.done); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL pause_err got=%b exp=0", bus.err); end
        tick(); #1;
    endtask

    // Only 60 beats: DRAIN entered in cycle 145, DONE due in cycle 145+256.
    task automatic test_timeout();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        #1;
        for (int c = 2; c <= 145; c++) tick();
        #1;
        total++; if (dbg_state !== 2'd2) begin bad++; $display("FAIL to_drain got=%0d exp=2", dbg_state); end
        for (int k = 1; k <= 256; k++) begin
            tick();
            bus.conv_valid = (k <= 60);
            #1;
            total++; if (bus.done !== (k == 256)) begin bad++; $display("FAIL to_done k=%0d got=%b exp=%b", k, bus.done, (k == 256)); end
        end
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL to_err got=%b exp=1", bus.err); end
        total++; if (bus.out_count !== 7'd60) begin bad++; $display("FAIL to_count got=%0d exp=60", bus.out_count); end
        tick(); #1;
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL to_idle got=%0d exp=0", dbg_state); end
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL to_err_sticky got=%b exp=1", bus.err); end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        #1;
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL to_err_clear got=%b exp=0", bus.err); end
        total++; if (bus.out_count !== 7'd0) begin bad++; $display("FAIL to_count_clear got=%0d exp=0", bus.out_count); end
        total++; if (bus.mem_addr !== 8'd0) begin bad++; $display("FAIL to_restart_addr got=%0d exp=0", bus.mem_addr); end
        do_reset();
    endtask

    // Reset at addr 80 after 10 beats; everything clears with no done pulse.
    task automatic test_reset_mid();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        #1;
        for (int c = 2; c <= 81; c++) begin
            tick();
            bus.conv_valid = (c >= 30 && c <= 39);
            #1;
        end
        total++; if (bus.mem_addr !== 8'd80) begin bad++; $display("FAIL rm_addr got=%0d exp=80", bus.mem_addr); end
        total++; if (bus.out_count !== 7'd10) begin bad++; $display("FAIL rm_count got=%0d exp=10", bus.out_count); end
        total++; if (bus.out_row !== 3'd1) begin bad++; $display("FAIL rm_row got=%0d exp=1", bus.out_row); end
        total++; if (bus.out_col !== 3'd2) begin bad++; $display("FAIL rm_col got=%0d exp=2", bus.out_col); end
        rst = 1'b1;
        #1;
        total++; if (bus.mem_rd_en !== 1'b0) begin bad++; $display("FAIL rm_rd_en got=%b exp=0", bus.mem_rd_en); end
        total++; if (bus.mem_addr !== 8'd0) begin bad++; $display("FAIL rm_addr0 got=%0d exp=0", bus.mem_addr); end
        total++; if (bus.dp_valid_in !== 1'b0) begin bad++; $display("FAIL rm_dpv got=%b exp=0", bus.dp_valid_in); end
        total++; if (bus.out_row !== 3'd0) begin bad++; $display("FAIL rm_row0 got=%0d exp=0", bus.out_row); end
        total++; if (bus.out_col !== 3'd0) begin bad++; $display("FAIL rm_col0 got=%0d exp=0", bus.out_col); end
        total++; if (bus.out_count !== 7'd0) begin bad++; $display("FAIL rm_count0 got=%0d exp=0", bus.out_count); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b exp=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rm_done got=%b exp=0", bus.done); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL rm_err got=%b exp=0", bus.err); end
        bus.conv_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick(); #1;
            total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rm_hold_done j=%0d got=%b exp=0", j, bus.done); end
        end
        rst = 1'b0;
        for (int j = 0; j < 2; j++) begin
            tick(); #1;
            total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rm_post_done j=%0d got=%b exp=0", j, bus.done); end
            total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rm_post_idle j=%0d got=%0d exp=0", j, dbg_state); end
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        #1;
        total++; if (bus.mem_addr !== 8'd0) begin bad++; $display("FAIL rm_restart_addr got=%0d exp=0", bus.mem_addr); end
        total++; if (bus.mem_rd_en !== 1'b1) begin bad++; $display("FAIL rm_restart_rd got=%b exp=1", bus.mem_rd_en); end
        tick(); #1;
        total++; if (bus.mem_addr !== 8'd1) begin bad++; $display("FAIL rm_restart_addr1 got=%0d exp=1", bus.mem_addr); end
        do_reset();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.start      = 1'b0;
        bus.pause      = 1'b0;
        bus.conv_valid = 1'b0;
        test_reset();
        test_nominal();
        test_ignored_idle();
        test_feed_overflow();
        test_pause();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
